// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC sharing controller.
package cordic_pkg;

  localparam int ANGLE_W  = 8;
  localparam int TRIG_W   = 8;
  localparam int TAG_ID_W = 3;  // wide enough for up to 8 requesters

  localparam logic signed [ANGLE_W-1:0] ANGLE_MAX = 8'sd100;
  localparam logic signed [ANGLE_W-1:0] ANGLE_MIN = -8'sd100;

  // Tag carried alongside the core pipeline for each issued angle
  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
    logic                sat;
  } tag_t;

  typedef struct packed {
    logic                      sat;
    logic signed [ANGLE_W-1:0] angle;
  } clamp_t;

  // Limit an angle to roughly +/-pi/2 in Q2.6, flagging when it had to be clamped
  function automatic clamp_t clamp_angle(input logic signed [ANGLE_W-1:0] a);
    clamp_t r;
    if (a > ANGLE_MAX) begin
      r.sat   = 1'b1;
      r.angle = ANGLE_MAX;
    end else if (a < ANGLE_MIN) begin
      r.sat   = 1'b1;
      r.angle = ANGLE_MIN;
    end else begin
      r.sat   = 1'b0;
      r.angle = a;
    end
    return r;
  endfunction

endpackage

// File: rtl/cordic_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts after the last accepted requester.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               accept
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] idx;
  logic            found;

  // Pick the first requester at or after the pointer, wrapping modulo NUM_REQ
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    if (!rst) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = ID_W'((32'(ptr) + k) % NUM_REQ);
        if (!found && req[idx]) begin
          grant[idx] = 1'b1;
          grant_id   = idx;
          found      = 1'b1;
        end
      end
    end
    accept = found;
  end

  // Move priority to the requester after the one just accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    end
  end

endmodule

// File: rtl/cordic_share_ctrl.sv
// Shares one fixed-latency CORDIC core among NUM_REQ requesters, tagging results by owner.
module cordic_share_ctrl
  import cordic_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int PIPE_LAT = 8,
  parameter int ID_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_angle,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           cor_in,
  input  logic [7:0]           cor_sine,
  input  logic [7:0]           cor_cosine,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_sine,
  output logic [7:0]           rsp_cosine,
  output logic                 rsp_sat,
  output logic                 busy
);

  logic [NUM_REQ-1:0]        grant;
  logic [ID_W-1:0]           grant_id;
  logic                      accept;
  logic signed [ANGLE_W-1:0] sel_angle;
  clamp_t                    clamped;

  // Stage 0 is loaded on the accept edge; stage PIPE_LAT lines up with the core output.
  tag_t tag_pipe [PIPE_LAT+1];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req_valid),
    .grant    (grant),
    .grant_id (grant_id),
    .accept   (accept)
  );

  assign req_ready = grant;

  // Select the granted requester's angle and clamp it into the core's legal range
  always_comb begin
    sel_angle = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) sel_angle = req_angle[8*i +: 8];
    end
    clamped = clamp_angle(sel_angle);
  end

  // Drive the core and push a tag for every accepted request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cor_in <= '0;
      for (int unsigned k = 0; k <= PIPE_LAT; k++) tag_pipe[k] <= '0;
    end else begin
      if (accept) begin
        cor_in      <= clamped.angle;
        tag_pipe[0] <= '{valid: 1'b1, id: TAG_ID_W'(grant_id), sat: clamped.sat};
      end else begin
        tag_pipe[0] <= '0;
      end
      for (int unsigned k = 1; k <= PIPE_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  // Capture the core result when its tag reaches the end of the pipe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_sine   <= '0;
      rsp_cosine <= '0;
      rsp_sat    <= 1'b0;
    end else begin
      rsp_valid <= tag_pipe[PIPE_LAT].valid;
      if (tag_pipe[PIPE_LAT].valid) begin
        rsp_id     <= ID_W'(tag_pipe[PIPE_LAT].id);
        rsp_sine   <= cor_sine;
        rsp_cosine <= cor_cosine;
        rsp_sat    <= tag_pipe[PIPE_LAT].sat;
      end
    end
  end

  // Busy while any tag is in flight or a response is being presented
  always_comb begin
    busy = rsp_valid;
    for (int unsigned k = 0; k <= PIPE_LAT; k++) busy = busy | tag_pipe[k].valid;
  end

endmodule

// File: tb/tb_cordic_share_ctrl.sv
// Bench for cordic_share_ctrl with a delay-line core stand-in and a transaction-level model.
module tb_cordic_share_ctrl;

  localparam int N  = 4;
  localparam int PL = 8;

  // Bit positions inside the packed observation vector
  localparam int RV  = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [N*8-1:0] req_angle;
  logic [N-1:0] req_ready;
  logic [7:0]   cor_in, cor_sine, cor_cosine;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [7:0]   rsp_sine, rsp_cosine;
  logic         rsp_sat, busy;

  cordic_share_ctrl #(
    .NUM_REQ  (N),
    .PIPE_LAT (PL),
    .ID_W     (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_angle  (req_angle),
    .req_ready  (req_ready),
    .cor_in     (cor_in),
    .cor_sine   (cor_sine),
    .cor_cosine (cor_cosine),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_sine   (rsp_sine),
    .rsp_cosine (rsp_cosine),
    .rsp_sat    (rsp_sat),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Core stand-in: PL-deep delay line, sine = angle, cosine = ~angle
  logic [7:0] core_d [PL];
  always @(posedge clk) begin
    core_d[0] <= cor_in;
    for (int k = 1; k < PL; k++) core_d[k] <= core_d[k-1];
  end
  assign cor_sine   = core_d[PL-1];
  assign cor_cosine = ~core_d[PL-1];

  typedef struct {
    int unsigned due;
    logic [1:0]  id;
    logic [7:0]  ang;
    logic        sat;
  } pend_t;

  pend_t       pend[$];
  logic [32:0] act_q[$];
  logic [32:0] exp_q[$];
  int unsigned cyc;
  int          errors, checks;
  int          m_ptr;
  logic [7:0]  m_cor, m_s, m_c;
  logic [1:0]  m_id;
  logic        m_sat;

  // One clock: sample DUT and model at negedge, then step to just past the next posedge
  task automatic cycle();
    logic [N-1:0] eg;
    logic         ev, ebusy, cs;
    logic [7:0]   ecor, ca;
    int           w, v;
    @(negedge clk);
    cyc++;
    eg = '0; ev = 1'b0; ebusy = 1'b0; w = 0;
    if (rst) begin
      pend.delete();
      m_ptr = 0; m_cor = '0; m_id = '0; m_s = '0; m_c = '0; m_sat = 1'b0;
    end
    ecor = m_cor;
    if (!rst) begin
      ebusy = (pend.size() != 0);
      if (pend.size() != 0 && pend[0].due == cyc) begin
        ev = 1'b1; m_id = pend[0].id; m_s = pend[0].ang; m_c = ~pend[0].ang; m_sat = pend[0].sat;
        void'(pend.pop_front());
      end
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (eg == '0 && req_valid[i]) begin eg[i] = 1'b1; w = i; end
      end
      if (eg != '0) begin
        v = int'($signed(req_angle[8*w +: 8]));
        if (v > 100)       begin ca = 8'd100;     cs = 1'b1; end
        else if (v < -100) begin ca = 8'(-100);   cs = 1'b1; end
        else               begin ca = 8'(v);      cs = 1'b0; end
        pend.push_back('{due: cyc + PL + 2, id: 2'(w), ang: ca, sat: cs});
        m_ptr = (w + 1) % N;
        m_cor = ca;
      end
    end
    act_q.push_back({req_ready, cor_in, rsp_valid, rsp_id, rsp_sine, rsp_cosine, rsp_sat, busy});
    exp_q.push_back({eg, ecor, ev, m_id, m_s, m_c, m_sat, ebusy});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    act_q.delete(); exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      req_valid = 4'($urandom) | 4'b0001;
      req_angle = $urandom;
      cycle();
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, cor_in, rsp_valid, rsp_id, rsp_sine, rsp_cosine, rsp_sat, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs act=%h exp=0",
               {req_ready, cor_in, rsp_valid, rsp_id, rsp_sine, rsp_cosine, rsp_sat, busy});
    end
    cycle();
    rst = 1'b0;
    req_valid = '0;
    repeat (2*PL) cycle();
    for (int i = 7; i < act_q.size(); i++) begin
      checks++;
      if (act_q[i][RV] !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_rsp cyc%0d act=%b exp=0", i, act_q[i][RV]);
      end
    end
    for (int i = 0; i < act_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL reset_cyc%0d act=%h exp=%h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_fairness();
    act_q.delete(); exp_q.delete();
    req_valid = '1;
    for (int i = 0; i < 8; i++) begin req_angle = $urandom; cycle(); end
    req_valid = '0;
    repeat (12) cycle();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (act_q[i][32:29] !== 4'(1 << (i % 4))) begin
        errors++;
        $display("FAIL fair_grant%0d act=%b exp=%b", i, act_q[i][32:29], 4'(1 << (i % 4)));
      end
      checks++;
      if (act_q[i+10][RV] !== 1'b1 || act_q[i+10][19:18] !== 2'(i % 4)) begin
        errors++;
        $display("FAIL fair_rsp%0d act_v=%b act_id=%0d exp_id=%0d", i, act_q[i+10][RV],
                 act_q[i+10][19:18], i % 4);
      end
    end
    for (int i = 0; i < act_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL fair_cyc%0d act=%h exp=%h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_latency();
    act_q.delete(); exp_q.delete();
    req_valid = 4'b0001; req_angle = '0; req_angle[7:0] = 8'sd32;
    cycle();
    req_valid = '0;
    repeat (12) cycle();
    checks++;
    if (act_q[0][32:29] !== 4'b0001) begin
      errors++; $display("FAIL lat_ready act=%b exp=0001", act_q[0][32:29]);
    end
    checks++;
    if (act_q[1][28:21] !== 8'd32) begin
      errors++; $display("FAIL lat_cor_in act=%0d exp=32", act_q[1][28:21]);
    end
    for (int i = 1; i <= 10; i++) begin
      checks++;
      if (act_q[i][RV] !== (i == 10)) begin
        errors++; $display("FAIL lat_rsp_valid cyc%0d act=%b exp=%b", i, act_q[i][RV], i == 10);
      end
    end
    checks++;
    if (act_q[10][19:18] !== 2'd0 || act_q[10][17:10] !== 8'd32 || act_q[10][1] !== 1'b0) begin
      errors++; $display("FAIL lat_rsp_data act=%h exp id=0 sine=32 sat=0", act_q[10]);
    end
    for (int i = 0; i < act_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL lat_cyc%0d act=%h exp=%h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_clamp();
    logic [7:0] ang [3];
    logic [7:0] want [3];
    logic       wsat [3];
    ang[0] = 8'sd127;  want[0] = 8'sd100;  wsat[0] = 1'b1;
    ang[1] = -8'sd128; want[1] = -8'sd100; wsat[1] = 1'b1;
    ang[2] = -8'sd99;  want[2] = -8'sd99;  wsat[2] = 1'b0;
    for (int t = 0; t < 3; t++) begin
      act_q.delete(); exp_q.delete();
      req_valid = 4'b0010; req_angle = '0; req_angle[15:8] = ang[t];
      cycle();
      req_valid = '0;
      repeat (11) cycle();
      checks++;
      if (act_q[1][28:21] !== want[t]) begin
        errors++; $display("FAIL clamp%0d_cor_in act=%0d exp=%0d", t, act_q[1][28:21], want[t]);
      end
      checks++;
      if (act_q[10][RV] !== 1'b1 || act_q[10][1] !== wsat[t] || act_q[10][19:18] !== 2'd1) begin
        errors++; $display("FAIL clamp%0d_rsp act=%h exp_sat=%b", t, act_q[10], wsat[t]);
      end
      for (int i = 0; i < act_q.size(); i++) begin
        checks++;
        if (act_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL clamp%0d_cyc%0d act=%h exp=%h", t, i, act_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_pointer();
    act_q.delete(); exp_q.delete();
    req_valid = 4'b0100; req_angle = $urandom;
    cycle();
    req_valid = 4'b1010; req_angle = $urandom;
    cycle();
    cycle();
    req_valid = '0;
    repeat (11) cycle();
    checks++;
    if (act_q[1][32:29] !== 4'b1000) begin
      errors++; $display("FAIL ptr_first act=%b exp=1000", act_q[1][32:29]);
    end
    checks++;
    if (act_q[2][32:29] !== 4'b0010) begin
      errors++; $display("FAIL ptr_second act=%b exp=0010", act_q[2][32:29]);
    end
    for (int i = 0; i < act_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL ptr_cyc%0d act=%h exp=%h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    act_q.delete(); exp_q.delete();
    req_valid = 4'b0100;
    for (int i = 0; i < 10; i++) begin req_angle = $urandom; cycle(); end
    req_valid = '0;
    repeat (12) cycle();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (act_q[i][32:29] !== 4'b0100 || act_q[i+10][RV] !== 1'b1) begin
        errors++;
        $display("FAIL b2b%0d act_grant=%b act_rsp=%b exp 0100/1", i, act_q[i][32:29], act_q[i+10][RV]);
      end
    end
    for (int i = 0; i < act_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_cyc%0d act=%h exp=%h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    act_q.delete(); exp_q.delete();
    for (int i = 0; i < 300; i++) begin
      req_valid = 4'($urandom);
      req_angle = $urandom;
      cycle();
    end
    req_valid = '0;
    repeat (12) cycle();
    for (int i = 0; i < act_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rand_cyc%0d act=%h exp=%h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_sweep();
    int k;
    act_q.delete(); exp_q.delete();
    for (int a = -99; a <= 99; a++) begin
      req_valid = 4'b0001; req_angle = $urandom; req_angle[7:0] = 8'(a);
      cycle();
      req_valid = '0;
      repeat (17) cycle();
    end
    k = 0;
    for (int a = -99; a <= 99; a++) begin
      checks++;
      if (act_q[k+10][RV] !== 1'b1 || act_q[k+10][19:18] !== 2'd0 ||
          act_q[k+10][1] !== 1'b0 || act_q[k+10][17:10] !== 8'(a) ||
          act_q[k+10][9:2] !== ~8'(a)) begin
        errors++; $display("FAIL sweep_a%0d act=%h", a, act_q[k+10]);
      end
      k += 18;
    end
    for (int i = 0; i < act_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL sweep_cyc%0d act=%h exp=%h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0;
    m_ptr = 0; m_cor = '0; m_id = '0; m_s = '0; m_c = '0; m_sat = 1'b0;
    rst = 1'b1; req_valid = '0; req_angle = '0;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    test_reset();
    test_fairness();
    test_latency();
    test_clamp();
    test_pointer();
    test_back_to_back();
    test_random();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
